// File: rtl/d_cache_write_buffer.sv
// d_cache_write_buffer: posted-write FIFO between the d-cache and the AXI bridge.
// Writes ack a cycle after accept; reads pass through once the FIFO has drained.
module d_cache_write_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up_req,
  input  logic        up_wr,
  input  logic [1:0]  up_size,
  input  logic [31:0] up_addr,
  input  logic [31:0] up_wdata,
  output logic [31:0] up_rdata,
  output logic        up_addr_ok,
  output logic        up_data_ok,
  output logic        down_req,
  output logic        down_wr,
  output logic [1:0]  down_size,
  output logic [31:0] down_addr,
  output logic [31:0] down_wdata,
  input  logic [31:0] down_rdata,
  input  logic        down_addr_ok,
  input  logic        down_data_ok,
  output logic        empty
);

  typedef enum logic [2:0] {
    IDLE,
    W_ADDR,
    W_DATA,
    R_ADDR,
    R_DATA
  } state_t;

  localparam logic [PTR_W:0]   FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   C_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] P_ONE = PTR_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             ack_q;

  logic [31:0] ent_addr [DEPTH];
  logic [1:0]  ent_size [DEPTH];
  logic [31:0] ent_data [DEPTH];
  logic [31:0] rd_addr;
  logic [1:0]  rd_size;

  logic rd_busy;
  logic push;
  logic pop;
  logic rd_acc;
  logic rd_ret;

  assign rd_busy = (state == R_ADDR) | (state == R_DATA);

  // A full FIFO refuses writes even while popping: no push-through.
  assign push = up_req & up_wr & (count < FULL) & ~rd_busy;

  assign rd_acc = up_req & ~up_wr & (state == IDLE)
                & (count == '0);

  assign pop = ((state == W_ADDR) & down_addr_ok & down_data_ok)
             | ((state == W_DATA) & down_data_ok);

  assign rd_ret = down_data_ok
                & (((state == R_ADDR) & down_addr_ok)
                  | (state == R_DATA));

  assign up_addr_ok = push | rd_acc;
  assign up_data_ok = ack_q | rd_ret;
  assign up_rdata   = rd_ret ? down_rdata : '0;
  assign empty      = (count == '0) & (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          state_nxt = W_ADDR;
        end else if (rd_acc) begin
          state_nxt = R_ADDR;
        end
      end
      W_ADDR: begin
        if (down_addr_ok) begin
          state_nxt = down_data_ok ? IDLE : W_DATA;
        end
      end
      W_DATA: begin
        if (down_data_ok) begin
          state_nxt = IDLE;
        end
      end
      R_ADDR: begin
        if (down_addr_ok) begin
          state_nxt = down_data_ok ? IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (down_data_ok) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    down_req   = 1'b0;
    down_wr    = 1'b0;
    down_size  = '0;
    down_addr  = '0;
    down_wdata = '0;
    unique case (state)
      W_ADDR: begin
        down_req   = 1'b1;
        down_wr    = 1'b1;
        down_size  = ent_size[rd_ptr];
        down_addr  = ent_addr[rd_ptr];
        down_wdata = ent_data[rd_ptr];
      end
      R_ADDR: begin
        down_req  = 1'b1;
        down_size = rd_size;
        down_addr = rd_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= push;
      if (push) begin
        wr_ptr <= wr_ptr + P_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + P_ONE;
      end
      unique case ({push, pop})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: ;
      endcase
    end
  end

  // Payload storage carries no reset; only the pointers qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= up_addr;
      ent_size[wr_ptr] <= up_size;
      ent_data[wr_ptr] <= up_wdata;
    end
    if (rd_acc) begin
      rd_addr <= up_addr;
      rd_size <= up_size;
    end
  end

endmodule

// File: tb/tb_d_cache_write_buffer.sv
// tb_d_cache_write_buffer: scoreboard bench for the posted-write buffer.
// Upstream requests push expected bridge transactions; the bridge model pops them.
module tb_d_cache_write_buffer;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        up_req = 1'b0;
  logic        up_wr = 1'b0;
  logic [1:0]  up_size = '0;
  logic [31:0] up_addr = '0;
  logic [31:0] up_wdata = '0;
  logic [31:0] up_rdata;
  logic        up_addr_ok;
  logic        up_data_ok;
  logic        down_req;
  logic        down_wr;
  logic [1:0]  down_size;
  logic [31:0] down_addr;
  logic [31:0] down_wdata;
  logic [31:0] down_rdata = '0;
  logic        down_addr_ok = 1'b0;
  logic        down_data_ok = 1'b0;
  logic        empty;

  txn_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  d_cache_write_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .up_req(up_req), .up_wr(up_wr),
    .up_size(up_size), .up_addr(up_addr),
    .up_wdata(up_wdata), .up_rdata(up_rdata),
    .up_addr_ok(up_addr_ok), .up_data_ok(up_data_ok),
    .down_req(down_req), .down_wr(down_wr),
    .down_size(down_size), .down_addr(down_addr),
    .down_wdata(down_wdata), .down_rdata(down_rdata),
    .down_addr_ok(down_addr_ok), .down_data_ok(down_data_ok),
    .empty(empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic up_write(input logic [31:0] a, input logic [1:0] s,
                          input logic [31:0] d, output int wait_n,
                          output bit ack1, output bit ack2);
    txn_t e;
    @(posedge clk); #1;
    up_req = 1; up_wr = 1; up_addr = a; up_size = s; up_wdata = d;
    wait_n = -1;
    for (int i = 0; i < 100 && wait_n < 0; i++) begin
      @(negedge clk);
      if (up_addr_ok) wait_n = i;
    end
    @(posedge clk); #1;
    up_req = 0; up_wr = 0;
    if (wait_n >= 0) begin
      e.wr = 1; e.addr = a; e.size = s; e.data = d;
      sb.push_back(e);
    end
    @(negedge clk); ack1 = up_data_ok;
    @(negedge clk); ack2 = up_data_ok;
  endtask

  task automatic up_read(input logic [31:0] a, input logic [1:0] s,
                         output int acc_cyc);
    txn_t e;
    @(posedge clk); #1;
    up_req = 1; up_wr = 0; up_addr = a; up_size = s;
    acc_cyc = -1;
    for (int i = 0; i < 100 && acc_cyc < 0; i++) begin
      @(negedge clk);
      if (up_addr_ok) acc_cyc = cyc;
    end
    @(posedge clk); #1;
    up_req = 0;
    if (acc_cyc >= 0) begin
      e.wr = 0; e.addr = a; e.size = s; e.data = '0;
      sb.push_back(e);
    end
  endtask

  // Bridge model: waits for down_req, handshakes, reports what it saw.
  task automatic bridge_serve(input bit both, input logic [31:0] rd,
                              output bit got, output txn_t t,
                              output bit rok, output logic [31:0] rdo,
                              output int done_cyc);
    got = 0; rok = 0; rdo = '0; t = '0; done_cyc = -1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = down_req;
    end
    if (!got) return;
    t.wr = down_wr; t.addr = down_addr; t.size = down_size;
    t.data = down_wr ? down_wdata : '0;
    down_addr_ok = 1; down_data_ok = both; down_rdata = rd;
    if (!both) begin
      @(posedge clk); #1;
      down_addr_ok = 0;
      @(negedge clk);
      down_data_ok = 1;
    end
    #1;
    rok = up_data_ok; rdo = up_rdata; done_cyc = cyc;
    @(posedge clk); #1;
    down_addr_ok = 0; down_data_ok = 0; down_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL reset_empty: got %b want 1", empty);
    end
    checks++;
    if ({down_req, down_wr, up_data_ok, up_addr_ok} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 0000",
               {down_req, down_wr, up_data_ok, up_addr_ok});
    end
    checks++;
    if ({down_addr, down_wdata, up_rdata} !== 96'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0",
                         {down_addr, down_wdata, up_rdata});
    end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic single_write(input string nm, input logic [31:0] a,
                              input logic [31:0] d);
    int w, dc; bit a1, a2, got, rok; txn_t t, e;
    logic [31:0] rdo;
    up_write(a, 2'd2, d, w, a1, a2);
    checks++;
    if (w !== 0) begin
      errors++; $display("FAIL %s_accept: got wait %0d want 0", nm, w);
    end
    checks++;
    if ({a1, a2} !== 2'b10) begin
      errors++; $display("FAIL %s_ack: got %b want 10", nm, {a1, a2});
    end
    bridge_serve(0, '0, got, t, rok, rdo, dc);
    e = sb.size() > 0 ? sb.pop_front() : '0;
    checks++;
    if (!got || t !== e) begin
      errors++; $display("FAIL %s_down: got %h want %h", nm, t, e);
    end
    @(negedge clk);
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL %s_empty: got %b want 1", nm, empty);
    end
  endtask

  task automatic test_single_write();
    single_write("t1", 32'h0000_1000, 32'hDEAD_BEEF);
  endtask

  task automatic test_full();
    int acc5, dc, hits; bit got, rok; txn_t t, e;
    logic [31:0] rdo;
    @(posedge clk); #1;
    up_req = 1; up_wr = 1; up_size = 2'd2;
    for (int i = 0; i < 4; i++) begin
      up_addr = 32'h100 + 32'(4 * i);
      up_wdata = 32'hA000_0000 | 32'(i);
      @(negedge clk);
      checks++;
      if (up_addr_ok !== 1'b1) begin
        errors++; $display("FAIL full_acc%0d: got %b want 1", i, up_addr_ok);
      end else begin
        e.wr = 1; e.addr = up_addr; e.size = 2; e.data = up_wdata;
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    up_addr = 32'h110; up_wdata = 32'hA000_0004;
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (up_addr_ok) hits++;
    end
    checks++;
    if (hits !== 0) begin
      errors++; $display("FAIL full_stall: got %0d accepts want 0", hits);
    end
    acc5 = -1;
    fork
      bridge_serve(1, '0, got, t, rok, rdo, dc);
      begin
        for (int i = 0; i < 50 && acc5 < 0; i++) begin
          @(negedge clk);
          if (up_addr_ok) acc5 = cyc;
        end
        @(posedge clk); #1;
        up_req = 0; up_wr = 0;
      end
    join
    if (acc5 >= 0) begin
      e.wr = 1; e.addr = 32'h110; e.size = 2; e.data = 32'hA000_0004;
      sb.push_back(e);
    end
    checks++;
    if (acc5 !== dc + 1) begin
      errors++; $display("FAIL full_5th: got cyc %0d want %0d", acc5, dc + 1);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) bridge_serve(i[0], '0, got, t, rok, rdo, dc);
      e = sb.size() > 0 ? sb.pop_front() : '0;
      checks++;
      if (!got || t !== e) begin
        errors++; $display("FAIL full_drain%0d: got %h want %h", i, t, e);
      end
    end
  endtask

  task automatic test_read_after_write();
    int w, racc, wdc, dc; bit a1, a2, got, rok; txn_t t, e;
    logic [31:0] rdo;
    up_write(32'h2000, 2'd2, 32'h11, w, a1, a2);
    fork
      up_read(32'h2000, 2'd2, racc);
      begin
        bridge_serve(0, '0, got, t, rok, rdo, wdc);
        e = sb.size() > 0 ? sb.pop_front() : '0;
        checks++;
        if (!got || t !== e) begin
          errors++; $display("FAIL raw_wr: got %h want %h", t, e);
        end
      end
    join
    checks++;
    if (racc < 0 || racc <= wdc) begin
      errors++; $display("FAIL raw_hold: got cyc %0d want > %0d", racc, wdc);
    end
    bridge_serve(0, 32'h1234_5678, got, t, rok, rdo, dc);
    e = sb.size() > 0 ? sb.pop_front() : '0;
    checks++;
    if (!got || t !== e) begin
      errors++; $display("FAIL raw_rd: got %h want %h", t, e);
    end
    checks++;
    if ({rok, rdo} !== {1'b1, 32'h1234_5678}) begin
      errors++; $display("FAIL raw_rdata: got %b/%h want 1/12345678",
                         rok, rdo);
    end
  endtask

  task automatic test_order_size();
    int w; bit a1, a2, got, rok; txn_t t, e;
    logic [31:0] rdo; int dc;
    up_write(32'h3003, 2'd0, 32'h0000_00C3, w, a1, a2);
    up_write(32'h3002, 2'd1, 32'h0000_B2B2, w, a1, a2);
    up_write(32'h3000, 2'd2, 32'hA1A1_A1A1, w, a1, a2);
    for (int i = 0; i < 3; i++) begin
      bridge_serve(i[0], '0, got, t, rok, rdo, dc);
      e = sb.size() > 0 ? sb.pop_front() : '0;
      checks++;
      if (!got || t !== e) begin
        errors++; $display("FAIL order%0d: got %h want %h", i, t, e);
      end
    end
  endtask

  task automatic test_same_cycle();
    int w, racc, dc; bit a1, a2, got, rok; txn_t t, e;
    logic [31:0] rdo;
    up_write(32'h4000, 2'd2, 32'h55AA_55AA, w, a1, a2);
    bridge_serve(1, '0, got, t, rok, rdo, dc);
    e = sb.size() > 0 ? sb.pop_front() : '0;
    checks++;
    if (!got || t !== e) begin
      errors++; $display("FAIL same_wr: got %h want %h", t, e);
    end
    @(negedge clk);
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL same_wr_empty: got %b want 1", empty);
    end
    up_read(32'h4004, 2'd1, racc);
    bridge_serve(1, 32'hCAFE_F00D, got, t, rok, rdo, dc);
    e = sb.size() > 0 ? sb.pop_front() : '0;
    checks++;
    if (!got || t !== e) begin
      errors++; $display("FAIL same_rd: got %h want %h", t, e);
    end
    checks++;
    if ({rok, rdo} !== {1'b1, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL same_rdata: got %b/%h want 1/cafef00d",
                         rok, rdo);
    end
    @(negedge clk);
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL same_rd_empty: got %b want 1", empty);
    end
  endtask

  task automatic test_reset_drain();
    int w; bit a1, a2, got;
    up_write(32'h5000, 2'd2, 32'h5000_0000, w, a1, a2);
    up_write(32'h5004, 2'd2, 32'h5000_0004, w, a1, a2);
    up_write(32'h5008, 2'd2, 32'h5000_0008, w, a1, a2);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = down_req;
    end
    down_addr_ok = 1;
    @(posedge clk); #1;
    down_addr_ok = 0;
    @(negedge clk);
    checks++;
    if ({got, down_req, empty} !== 3'b100) begin
      errors++; $display("FAIL rstd_pre: got %b want 100",
                         {got, down_req, empty});
    end
    rst = 1;
    #1;
    checks++;
    if ({down_req, empty, dut.count} !== {1'b0, 1'b1, 3'd0}) begin
      errors++; $display("FAIL rstd_post: got %b want 01000",
                         {down_req, empty, dut.count});
    end
    sb.delete();
    @(posedge clk); #1;
    rst = 0;
    single_write("rstd_t1", 32'h0000_6000, 32'h600D_600D);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_full();
    test_read_after_write();
    test_order_size();
    test_same_cycle();
    test_reset_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
